// File: rtl/mvu_rdc_reader_if.sv
// Bundle of command, MVU read-port and output-stream signals for the
// mvu_rdc_reader. The reader uses the master view; the MVU/host side uses slave.
interface mvu_rdc_reader_if #(
    parameter int BDBANKA = 14,
    parameter int BDBANKW = 128,
    parameter int BSTRIDE = 15,
    parameter int BCOUNT  = 15
);
    // command
    logic               start;
    logic [BDBANKA-1:0] cfg_base;
    logic [BSTRIDE-1:0] cfg_stride;
    logic [BCOUNT-1:0]  cfg_count;
    logic               busy;
    logic               done;
    // MVU data-bank read port
    logic               rdc_en;
    logic               rdc_grnt;
    logic [BDBANKA-1:0] rdc_addr;
    logic [BDBANKW-1:0] rdc_word;
    // output stream
    logic               out_valid;
    logic               out_ready;
    logic [BDBANKW-1:0] out_word;
    logic               out_last;

    modport master (
        input  start, cfg_base, cfg_stride, cfg_count, rdc_grnt, rdc_word, out_ready,
        output busy, done, rdc_en, rdc_addr, out_valid, out_word, out_last
    );

    modport slave (
        output start, cfg_base, cfg_stride, cfg_count, rdc_grnt, rdc_word, out_ready,
        input  busy, done, rdc_en, rdc_addr, out_valid, out_word, out_last
    );
endinterface

// File: rtl/mvu_rdc_reader.sv
// Read-side client for an MVU data-bank read port: issues strided read
// requests, holds each until granted, captures the returned words after a
// fixed latency and streams them out in order through a credit-limited
// first-word-fall-through FIFO with a registered head.
module mvu_rdc_reader #(
    parameter int N       = 64,
    parameter int BDBANKA = 14,
    parameter int BDBANKW = 2 * N,
    parameter int BSTRIDE = 15,
    parameter int BCOUNT  = 15,
    parameter int RDLAT   = 2,
    parameter int DEPTH   = 4
) (
    input logic              clk,
    input logic              rst,
    mvu_rdc_reader_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e             state_q;
    logic [BDBANKA-1:0] addr_q;
    logic [BDBANKA-1:0] stride_q;
    logic [BCOUNT-1:0]  count_q;
    logic [BCOUNT-1:0]  issued_q;
    logic [BCOUNT-1:0]  recv_q;
    logic               rdc_en_q;
    logic               done_zero_q;

    logic [RDLAT-1:0]   pipe_q;
    logic [RDLAT-1:0]   pipe_d;

    logic [BDBANKW-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]   mem_last_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      rd_ptr_n;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_n;
    // words granted but not yet accepted downstream (pipe + FIFO)
    logic [CW-1:0]      outst_q;
    logic [CW-1:0]      outst_n;

    logic               out_valid_q;
    logic               out_last_q;
    logic [BDBANKW-1:0] out_word_q;

    logic [BSTRIDE-1:0] cfg_stride_w;
    logic               grant;
    logic               push;
    logic               pop;
    logic               push_last;
    logic               accept;
    logic               last_grant;
    logic               head_from_input;

    assign cfg_stride_w = bus.cfg_stride;

    // Handshake decode and occupancy bookkeeping
    always_comb begin
        grant           = rdc_en_q & bus.rdc_grnt;
        push            = pipe_q[RDLAT-1];
        pop             = out_valid_q & bus.out_ready;
        push_last       = (recv_q == count_q - BCOUNT'(1));
        // no acceptance in the zero-count done cycle
        accept          = (state_q == StIdle) & ~done_zero_q & bus.start;
        last_grant      = grant & ((issued_q + BCOUNT'(1)) == count_q);
        cnt_n           = cnt_q + CW'(push) - CW'(pop);
        outst_n         = outst_q + CW'(grant) - CW'(pop);
        rd_ptr_n        = rd_ptr_q + PW'(pop);
        // FIFO empty after this cycle's pop: the incoming word becomes the head
        head_from_input = (cnt_q == CW'(0)) | ((cnt_q == CW'(1)) & pop);
        pipe_d          = pipe_q << 1;
        pipe_d[0]       = grant;
    end

    // Command FSM and request generation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            rdc_en_q    <= 1'b0;
            done_zero_q <= 1'b0;
        end else begin
            done_zero_q <= 1'b0;
            if (grant) begin
                addr_q   <= addr_q + stride_q;
                issued_q <= issued_q + BCOUNT'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        // stride zero-extended/truncated to the address width: sum wraps
                        stride_q <= BDBANKA'(cfg_stride_w);
                        count_q  <= bus.cfg_count;
                        if (bus.cfg_count == '0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            addr_q   <= bus.cfg_base;
                            issued_q <= '0;
                            rdc_en_q <= 1'b1;
                            state_q  <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (last_grant) begin
                        rdc_en_q <= 1'b0;
                        state_q  <= StDrain;
                    end else if (!rdc_en_q || grant) begin
                        // credit gates only the raising of a new request
                        rdc_en_q <= (outst_n < CW'(DEPTH));
                    end
                end
                StDrain: begin
                    if (pop && out_last_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Latency pipe, FIFO pointers and registered stream head
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            outst_q     <= '0;
            recv_q      <= '0;
            mem_last_q  <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            rd_ptr_q <= rd_ptr_n;
            cnt_q    <= cnt_n;
            outst_q  <= outst_n;
            if (push) begin
                mem_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
                recv_q               <= recv_q + BCOUNT'(1);
            end else if (accept) begin
                recv_q <= '0;
            end
            out_valid_q <= (cnt_n != '0);
            if (cnt_n == '0) begin
                out_last_q <= 1'b0;
            end else if (head_from_input) begin
                out_word_q <= bus.rdc_word;
                out_last_q <= push_last;
            end else begin
                out_word_q <= mem_q[rd_ptr_n];
                out_last_q <= mem_last_q[rd_ptr_n];
            end
        end
    end

    // FIFO data storage; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rdc_word;
        end
    end

    // Credit accounting must make a write into a full FIFO impossible
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (cnt_q == CW'(DEPTH))));

    assign bus.busy      = (state_q != StIdle) | done_zero_q;
    assign bus.done      = done_zero_q | ((state_q == StDrain) & pop & out_last_q);
    assign bus.rdc_en    = rdc_en_q;
    assign bus.rdc_addr  = addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mvu_rdc_reader.sv
// Bench for mvu_rdc_reader: table of directed commands plus hand-written
// stall, backpressure, zero-count, busy-start and mid-run reset sequences.
module tb_mvu_rdc_reader;

    localparam int N       = 64;
    localparam int BDBANKA = 14;
    localparam int BDBANKW = 128;
    localparam int BSTRIDE = 15;
    localparam int BCOUNT  = 15;
    localparam int RDLAT   = 2;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mvu_rdc_reader_if #(
        .BDBANKA(BDBANKA), .BDBANKW(BDBANKW), .BSTRIDE(BSTRIDE), .BCOUNT(BCOUNT)
    ) bus ();

    mvu_rdc_reader #(
        .N(N), .BDBANKA(BDBANKA), .BDBANKW(BDBANKW), .BSTRIDE(BSTRIDE),
        .BCOUNT(BCOUNT), .RDLAT(RDLAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [13:0]      base;
        logic [14:0]      stride;
        logic [14:0]      count;
        logic [3:0][13:0] exp;   // exp[0] is the first address
    } vec_t;

    vec_t vecs [5];

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int start_cyc = -1, first_en = -1, first_gr = -1, first_val = -1, last_acc = -1;
    int done_cnt = 0, en_cycles = 0, inflight = 0;
    logic [13:0]  granted [$];
    logic [128:0] recv [$];
    logic [13:0]  exp_q [$];
    logic         prev_wait = 1'b0;
    logic [13:0]  prev_addr = '0;

    function automatic logic [127:0] word_of(input logic [13:0] a);
        return {4{2'b10, a, 2'b01, ~a}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MVU read-port model: data for a granted address appears RDLAT cycles later
    logic [RDLAT-1:0] rsp_v = '0;
    logic [13:0]      rsp_a [RDLAT];
    always @(posedge clk) begin
        rsp_v    <= {rsp_v[RDLAT-2:0], bus.rdc_en & bus.rdc_grnt};
        rsp_a[0] <= bus.rdc_addr;
        for (int i = 1; i < RDLAT; i++) rsp_a[i] <= rsp_a[i-1];
    end
    assign bus.rdc_word = rsp_v[RDLAT-1] ? word_of(rsp_a[RDLAT-1]) : {4{32'hDEADBEEF}};

    // Monitor: records grants, accepted words, done pulses and timing marks
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            inflight  = 0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check("hold_en", bus.rdc_en, 1);
                check("hold_addr", bus.rdc_addr, prev_addr);
            end
            prev_wait = bus.rdc_en && !bus.rdc_grnt;
            prev_addr = bus.rdc_addr;
            if (bus.start && !bus.busy) begin
                start_cyc = cyc; first_en = -1; first_gr = -1; first_val = -1; last_acc = -1;
            end
            if (bus.rdc_en) begin
                en_cycles++;
                if (first_en < 0) first_en = cyc;
            end
            if (bus.rdc_en && bus.rdc_grnt) begin
                granted.push_back(bus.rdc_addr);
                inflight++;
                check("credit", inflight <= DEPTH, 1);
                if (first_gr < 0) first_gr = cyc;
            end
            if (bus.out_valid && first_val < 0) first_val = cyc;
            if (bus.out_valid && bus.out_ready) begin
                recv.push_back({bus.out_last, bus.out_word});
                inflight--;
                if (bus.out_last) last_acc = cyc;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        granted.delete();
        recv.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_cmd(input logic [13:0] base, input logic [14:0] stride,
                           input logic [14:0] count);
        tick();
        bus.start = 1'b1; bus.cfg_base = base; bus.cfg_stride = stride; bus.cfg_count = count;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_done_seen"}, done_cnt > 0, 1);
        @(negedge clk);
        check({tag, "_busy_after"}, bus.busy, 0);
    endtask

    task automatic verify(input string tag);
        check({tag, "_ngrant"}, granted.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < granted.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), granted[i], exp_q[i]);
        check({tag, "_nrecv"}, recv.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < recv.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), recv[i][127:0], word_of(exp_q[i]));
            check($sformatf("%s_last%0d", tag, i), recv[i][128], i == exp_q.size() - 1);
        end
        check({tag, "_ndone"}, done_cnt, 1);
    endtask

    initial begin
        bus.start = 1'b0; bus.cfg_base = '0; bus.cfg_stride = '0; bus.cfg_count = '0;
        bus.rdc_grnt = 1'b1; bus.out_ready = 1'b1;

        vecs[0] = '{14'h0010, 15'd1,      15'd4, {14'h0013, 14'h0012, 14'h0011, 14'h0010}};
        vecs[1] = '{14'h3FFE, 15'd3,      15'd3, {14'h0000, 14'h0004, 14'h0001, 14'h3FFE}};
        vecs[2] = '{14'h0100, 15'h0010,   15'd2, {14'h0000, 14'h0000, 14'h0110, 14'h0100}};
        vecs[3] = '{14'h2000, 15'h7FFF,   15'd3, {14'h0000, 14'h1FFE, 14'h1FFF, 14'h2000}};
        vecs[4] = '{14'h0005, 15'd0,      15'd1, {14'h0000, 14'h0000, 14'h0000, 14'h0005}};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rdc_en", bus.rdc_en, 0);
        check("rst_rdc_addr", bus.rdc_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_word", bus.out_word, 0);
        check("rst_out_last", bus.out_last, 0);

        // directed command table, grant and ready held high
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            clear();
            for (int i = 0; i < int'(vecs[v].count); i++) exp_q.push_back(vecs[v].exp[i]);
            run_cmd(vecs[v].base, vecs[v].stride, vecs[v].count);
            @(negedge clk);
            check({tag, "_busy_on"}, bus.busy, 1);
            wait_done(tag);
            #1;
            verify(tag);
            check({tag, "_lat_en"}, first_en - start_cyc, 1);
            check({tag, "_lat_valid"}, first_val - first_gr, RDLAT + 1);
            check({tag, "_thruput"}, last_acc - first_val, int'(vecs[v].count) - 1);
        end

        // grant stall on the second request
        clear();
        for (int i = 0; i < 4; i++) exp_q.push_back(14'h0010 + 14'(i));
        run_cmd(14'h0010, 15'd1, 15'd4);
        tick();
        bus.rdc_grnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_en%0d", k), bus.rdc_en, 1);
            check($sformatf("stall_addr%0d", k), bus.rdc_addr, 14'h0011);
            tick();
        end
        bus.rdc_grnt = 1'b1;
        wait_done("stall");
        #1;
        verify("stall");

        // backpressure: ready low for 20 cycles
        clear();
        for (int i = 0; i < 16; i++) exp_q.push_back(14'h0020 + 14'(2 * i));
        bus.out_ready = 1'b0;
        run_cmd(14'h0020, 15'd2, 15'd16);
        repeat (19) tick();
        @(negedge clk);
        #1;
        check("bp_grants", granted.size(), DEPTH);
        check("bp_valid", bus.out_valid, 1);
        check("bp_head", bus.out_word, word_of(14'h0020));
        check("bp_last", bus.out_last, 0);
        tick();
        bus.out_ready = 1'b1;
        wait_done("bp");
        #1;
        verify("bp");

        // zero count, plus a start in the done cycle that must be ignored
        clear();
        en_cycles = 0;
        tick();
        bus.start = 1'b1; bus.cfg_base = 14'h0050; bus.cfg_stride = 15'd1; bus.cfg_count = 15'd0;
        @(negedge clk);
        check("zero_done_early", bus.done, 0);
        tick();
        bus.cfg_count = 15'd2;
        @(negedge clk);
        check("zero_done_pulse", bus.done, 1);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("zero_done_end", bus.done, 0);
        check("zero_busy_end", bus.busy, 0);
        repeat (5) tick();
        @(negedge clk);
        #1;
        check("zero_no_en", en_cycles, 0);
        check("zero_no_grant", granted.size(), 0);
        check("zero_ndone", done_cnt, 1);

        // start while busy is ignored
        clear();
        for (int i = 0; i < 3; i++) exp_q.push_back(14'h0040 + 14'(i));
        run_cmd(14'h0040, 15'd1, 15'd3);
        tick();
        bus.start = 1'b1; bus.cfg_base = 14'h3000; bus.cfg_stride = 15'd5; bus.cfg_count = 15'd5;
        tick();
        bus.start = 1'b0;
        wait_done("busy_start");
        repeat (5) tick();
        @(negedge clk);
        #1;
        verify("busy_start");

        // reset after 3 of 8 grants
        clear();
        run_cmd(14'h0100, 15'd1, 15'd8);
        begin
            int k = 0;
            while (granted.size() < 3 && k < 50) begin
                @(negedge clk);
                #1;
                k++;
            end
            check("rr_reach3", granted.size() >= 3, 1);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rr_busy", bus.busy, 0);
        check("rr_done", bus.done, 0);
        check("rr_rdc_en", bus.rdc_en, 0);
        check("rr_rdc_addr", bus.rdc_addr, 0);
        check("rr_out_valid", bus.out_valid, 0);
        check("rr_out_word", bus.out_word, 0);
        check("rr_out_last", bus.out_last, 0);
        #1;
        clear();
        repeat (8) tick();
        @(negedge clk);
        #1;
        check("rr_no_late_word", recv.size(), 0);
        check("rr_no_grant", granted.size(), 0);
        check("rr_no_done", done_cnt, 0);

        clear();
        exp_q.push_back(14'h0200);
        exp_q.push_back(14'h0201);
        run_cmd(14'h0200, 15'd1, 15'd2);
        wait_done("post_rst");
        #1;
        verify("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
